// File: rtl/mux_2to1_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_2to1_arbiter_if
//   Bundles the two requester handshakes and the shared mux output of the
//   2:1 round-robin arbiter.
//
//   Handshake: a requester raises x_req_i and keeps it high for as long as it
//   wants the datapath. x_gnt_o high means that side owns the datapath this
//   cycle, and x_data_i is sampled on every rising edge at which it owns it.
//   Dropping x_req_i gives up ownership at the next edge. The sampled word
//   appears on y_o one cycle later, qualified by y_vld_o.
//
//   Signals
//     a_req_i / b_req_i    requester wants the datapath
//     a_data_i / b_data_i  requester data, DATA_W bits
//     a_gnt_o / b_gnt_o    requester owns the datapath this cycle
//     sel_o                mux select: 0 = A, 1 = B
//     y_o                  registered mux output, DATA_W bits
//     y_vld_o              y_o holds data sampled under a grant
//
//   Modports
//     master  requester side: drives req/data, observes grants and output
//     slave   arbiter side: observes req/data, drives grants and output
// -----------------------------------------------------------------------------
interface mux_2to1_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              a_req_i;
   logic [DATA_W-1:0] a_data_i;
   logic              b_req_i;
   logic [DATA_W-1:0] b_data_i;
   logic              a_gnt_o;
   logic              b_gnt_o;
   logic              sel_o;
   logic [DATA_W-1:0] y_o;
   logic              y_vld_o;

   modport master (
      output a_req_i, a_data_i, b_req_i, b_data_i,
      input  a_gnt_o, b_gnt_o, sel_o, y_o, y_vld_o
   );

   modport slave (
      input  a_req_i, a_data_i, b_req_i, b_data_i,
      output a_gnt_o, b_gnt_o, sel_o, y_o, y_vld_o
   );
endinterface

// File: rtl/mux_2to1_arbiter.sv
// -----------------------------------------------------------------------------
// mux_2to1_arbiter
//   Round-robin arbiter for a 2:1 mux datapath shared by requesters A and B.
//   It is the only source of the mux select and registers the selected word.
//
//   Optional feature: define ARB_HOLD_LIMIT_EN to bound how long one side may
//   keep the grant while the other side is waiting (MAX_HOLD cycles). Without
//   it, the owner keeps the grant until it drops its request.
//
//   Ports
//     clk             rising-edge clock
//     reset_n         synchronous reset, active low
//     bus             mux_2to1_arbiter_if.slave (req/data in, gnt/sel/y out)
//     o_dbg_state     current FSM state (0 IDLE, 1 GNT_A, 2 GNT_B)
//     o_dbg_hold_cnt  consecutive-hold counter (always 0 without the limit)
// -----------------------------------------------------------------------------
module mux_2to1_arbiter #(
   parameter int  DATA_W   = 8,
   parameter int  MAX_HOLD = 4,
   localparam int HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   mux_2to1_arbiter_if.slave   bus,
   output logic [1:0]          o_dbg_state,
   output logic [HC_W-1:0]     o_dbg_hold_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_last;     // last owner: 0 = A, 1 = B
   logic              r_sel;
   logic [DATA_W-1:0] r_y;
   logic              r_y_vld;
   logic              w_hold_hit; // owner has used up its hold budget

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   logic [HC_W-1:0] r_hold_cnt;

   assign w_hold_hit = (r_hold_cnt == HOLD_LAST);

   // Counts the cycles the current owner has already held the grant;
   // restarts on every new grant and saturates at its last value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hold_cnt <= '0;
      end else if (w_next != ST_IDLE && w_next != r_state) begin
         r_hold_cnt <= '0;
      end else if (w_next != ST_IDLE && r_hold_cnt != HOLD_LAST) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   assign o_dbg_hold_cnt = r_hold_cnt;
`else
   assign w_hold_hit     = 1'b0;
   assign o_dbg_hold_cnt = '0;
`endif

   // Next-state logic. A tie from IDLE goes to the side that did not own the
   // datapath last; an owner that drops its request hands straight over to a
   // waiting peer without passing through IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.a_req_i && bus.b_req_i) w_next = r_last ? ST_GNT_A : ST_GNT_B;
            else if (bus.a_req_i)           w_next = ST_GNT_A;
            else if (bus.b_req_i)           w_next = ST_GNT_B;
            else                            w_next = ST_IDLE;
         end
         ST_GNT_A: begin
            if (bus.a_req_i) w_next = (bus.b_req_i && w_hold_hit) ? ST_GNT_B : ST_GNT_A;
            else if (bus.b_req_i) w_next = ST_GNT_B;
            else                  w_next = ST_IDLE;
         end
         ST_GNT_B: begin
            if (bus.b_req_i) w_next = (bus.a_req_i && w_hold_hit) ? ST_GNT_A : ST_GNT_B;
            else if (bus.a_req_i) w_next = ST_GNT_A;
            else                  w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;   // B counts as last owner so A wins the first tie
         r_sel   <= 1'b0;
         r_y     <= '0;
         r_y_vld <= 1'b0;
      end else begin
         r_state <= w_next;
         // last and sel follow the owner; both hold while IDLE
         if (w_next == ST_GNT_A) begin
            r_last <= 1'b0;
            r_sel  <= 1'b0;
         end else if (w_next == ST_GNT_B) begin
            r_last <= 1'b1;
            r_sel  <= 1'b1;
         end
         // Datapath samples under the grant that is current at this edge
         case (r_state)
            ST_GNT_A: begin
               r_y     <= bus.a_data_i;
               r_y_vld <= 1'b1;
            end
            ST_GNT_B: begin
               r_y     <= bus.b_data_i;
               r_y_vld <= 1'b1;
            end
            default: r_y_vld <= 1'b0;
         endcase
      end
   end

   assign bus.a_gnt_o = (r_state == ST_GNT_A);
   assign bus.b_gnt_o = (r_state == ST_GNT_B);
   assign bus.sel_o   = r_sel;
   assign bus.y_o     = r_y;
   assign bus.y_vld_o = r_y_vld;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Bench for mux_2to1_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against an
// ownership-level model of the arbitration rules.
module tb_mux_2to1_arbiter;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mux_2to1_arbiter_if #(.DATA_W(DATA_W)) bus ();
  logic [1:0]      dbg_state;
  logic [HC_W-1:0] dbg_hold_cnt;

  mux_2to1_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_hold_cnt (dbg_hold_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner: 0 none, 1 A, 2 B. run = number of cycles the owner has held the
  // grant so far, counting the first granted cycle as 1.
  int              m_owner, m_last, m_run;
  logic [DATA_W-1:0] m_y;
  logic            m_vld, m_sel;
  bit              m_valid = 1'b0;
  int              m_next;

  function automatic int next_owner(input int owner, input int last, input int run,
                                    input logic a, input logic b);
    logic [2:0] want;
    int other;
    want = {b, a, 1'b0};
    if (owner == 0) begin
      if (a && b) return (last == 1) ? 2 : 1;
      if (a) return 1;
      if (b) return 2;
      return 0;
    end
    other = 3 - owner;
    if (want[owner]) begin
      if (LIMIT_EN && run >= MAX_HOLD && want[other]) return other;
      return owner;
    end
    if (want[other]) return other;
    return 0;
  endfunction

  always_comb m_next = next_owner(m_owner, m_last, m_run, bus.a_req_i, bus.b_req_i);

  always @(posedge clk) begin
    if (!reset_n) begin
      m_owner <= 0;
      m_last  <= 2;
      m_run   <= 0;
      m_y     <= '0;
      m_vld   <= 1'b0;
      m_sel   <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      if (m_owner == 1) begin
        m_y <= bus.a_data_i; m_vld <= 1'b1;
      end else if (m_owner == 2) begin
        m_y <= bus.b_data_i; m_vld <= 1'b1;
      end else begin
        m_vld <= 1'b0;
      end
      m_owner <= m_next;
      if (m_next != 0) begin
        m_last <= m_next;
        m_sel  <= (m_next == 2);
        m_run  <= (m_next == m_owner) ? m_run + 1 : 1;
      end else begin
        m_run <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_a_gnt", 32'(bus.a_gnt_o), 32'(m_owner == 1));
      check("model_b_gnt", 32'(bus.b_gnt_o), 32'(m_owner == 2));
      check("model_sel",   32'(bus.sel_o),   32'(m_sel));
      check("model_y_vld", 32'(bus.y_vld_o), 32'(m_vld));
      check("model_y",     32'(bus.y_o),     32'(m_y));
      check("gnt_onehot0", 32'(bus.a_gnt_o & bus.b_gnt_o), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b);
    bus.a_req_i = a;
    bus.b_req_i = b;
  endtask

  task automatic expect_out(input string tag, input logic a_g, input logic b_g,
                            input logic sel, input logic vld);
    check({tag, "_a_gnt"}, 32'(bus.a_gnt_o), 32'(a_g));
    check({tag, "_b_gnt"}, 32'(bus.b_gnt_o), 32'(b_g));
    check({tag, "_sel"},   32'(bus.sel_o),   32'(sel));
    check({tag, "_vld"},   32'(bus.y_vld_o), 32'(vld));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n      = 1'b0;
    bus.a_data_i = '0;
    bus.b_data_i = '0;
    drive(1'b1, 1'b1);

    // Reset held two cycles with both requests high
    step(); step();
    expect_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_y", 32'(bus.y_o), 32'h0);
    reset_n = 1'b1;
    step();
    expect_out("first_tie", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    step(); step();

    // Single requester A
    bus.a_data_i = 8'h05;
    drive(1'b1, 1'b0);
    step();
    expect_out("single_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("single_c2", 1'b1, 1'b0, 1'b0, 1'b1);
    check("single_y", 32'(bus.y_o), 32'h05);
    step();

    // A drops while B requests: direct handover
    bus.b_data_i = 8'h10;
    drive(1'b0, 1'b1);
    step();
    expect_out("handover", 1'b0, 1'b1, 1'b1, 1'b1);
    check("handover_y_a", 32'(bus.y_o), 32'h05);
    step();
    check("handover_y_b", 32'(bus.y_o), 32'h10);
    drive(1'b0, 1'b0);
    step();
    expect_out("release", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    expect_out("idle", 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_y_hold", 32'(bus.y_o), 32'h10);

    // Ties alternate: last was B -> A, then B
    drive(1'b1, 1'b1);
    step();
    expect_out("tie1", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1);
    step();
    expect_out("tie2", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of B's grant
    reset_n = 1'b0;
    step();
    expect_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_y", 32'(bus.y_o), 32'h0);
    reset_n = 1'b1;

    // Both requests stuck high: hold limit decides when B gets in
    for (int i = 0; i < 8; i++) begin
      step();
      if (LIMIT_EN) check("hold_a_gnt", 32'(bus.a_gnt_o), 32'(i < MAX_HOLD));
      else          check("hold_a_gnt", 32'(bus.a_gnt_o), 32'd1);
    end
    drive(1'b0, 1'b0);
    step(); step();

    // Randomized traffic with phase-varying request density
    for (int blk = 0; blk < 20; blk++) begin
      int pa, pb;
      pa = $urandom_range(10, 95);
      pb = $urandom_range(10, 95);
      for (int c = 0; c < 100; c++) begin
        bus.a_req_i  = ($urandom_range(0, 99) < pa);
        bus.b_req_i  = ($urandom_range(0, 99) < pb);
        bus.a_data_i = DATA_W'($urandom);
        bus.b_data_i = DATA_W'($urandom);
        reset_n      = ($urandom_range(0, 79) != 0);
        step();
      end
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
